// File: rtl/curr_ctrl_debug_pkg.sv
// Shared types and constants for the current-controller debug capture engine.
package curr_ctrl_debug_pkg;

    localparam int DBG_ADDR_W = 9;
    localparam int DBG_DATA_W = 32;
    localparam int DBG_DEPTH  = 512;

    localparam logic [DBG_DATA_W/8-1:0] DBG_BE_ALL = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRETRIG,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } cap_state_t;

endpackage

// File: rtl/curr_ctrl_debug_capture.sv
// Ring-buffer capture of debug samples into RAM port 2 with pre/post trigger framing.
// Optional build macro CURR_CTRL_DEBUG_CAPTURE_DECIMATE_EN adds sample decimation (decim input).
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | no capture; samples dropped
// ST_PRETRIG | filling minimum history; trigger ignored
// ST_ARMED   | ring running, waiting for a qualified trigger
// ST_POST    | writing post-trigger samples until post_rem reaches 0
// ST_DONE    | record frozen for software readout
module curr_ctrl_debug_capture
    import curr_ctrl_debug_pkg::*;
#(
    parameter int ADDR_W  = DBG_ADDR_W,
    parameter int DATA_W  = DBG_DATA_W,
    parameter int PRE_MIN = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arm,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   post_len,
    input  logic                sample_valid,
    input  logic [DATA_W-1:0]   sample_data,
    input  logic                trigger,
`ifdef CURR_CTRL_DEBUG_CAPTURE_DECIMATE_EN
    input  logic [7:0]          decim,
`endif
    output logic [ADDR_W-1:0]   ram_address,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_clken,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   trig_addr,
    output logic                wrapped
);

    localparam int PRE_W = $clog2(PRE_MIN + 1);

    cap_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [PRE_W-1:0]    pre_cnt;
    logic [ADDR_W-1:0]   post_rem;
    logic                write_q;
    logic                active;
    logic                start;
    logic                valid_ok;
    logic                accept;

    assign active   = (state_q == ST_PRETRIG) || (state_q == ST_ARMED) || (state_q == ST_POST);
    assign start    = arm && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // A sample arriving with abort is dropped so at most the already-registered write follows.
    assign valid_ok = sample_valid && active && !abort;

`ifdef CURR_CTRL_DEBUG_CAPTURE_DECIMATE_EN
    logic [7:0] decim_q;
    logic [7:0] decim_cnt;
    logic       force_take;

    // A trigger on a skipped sample must still land in the record.
    assign force_take = trigger && (state_q == ST_ARMED);
    assign accept     = valid_ok && ((decim_cnt == 8'd0) || force_take);

    always_ff @(posedge clk) begin
        if (reset) begin
            decim_q   <= 8'd0;
            decim_cnt <= 8'd0;
        end else if (start) begin
            decim_q   <= decim;
            decim_cnt <= 8'd0;
        end else if (valid_ok) begin
            if (accept) begin
                decim_cnt <= decim_q;
            end else begin
                decim_cnt <= decim_cnt - 8'd1;
            end
        end
    end
`else
    assign accept = valid_ok;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) state_d = ST_PRETRIG;
            end
            ST_PRETRIG: begin
                if (accept && (pre_cnt == PRE_W'(PRE_MIN - 1))) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (accept && trigger) begin
                    state_d = (post_rem == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (accept && (post_rem == ADDR_W'(1))) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_ptr        <= '0;
            pre_cnt       <= '0;
            post_rem      <= '0;
            wrapped       <= 1'b0;
            trig_addr     <= '0;
            write_q       <= 1'b0;
            ram_address   <= '0;
            ram_writedata <= '0;
        end else begin
            state_q <= state_d;
            write_q <= accept;
            if (start) begin
                wr_ptr   <= '0;
                pre_cnt  <= '0;
                wrapped  <= 1'b0;
                post_rem <= post_len;
            end
            if (accept) begin
                ram_address   <= wr_ptr;
                ram_writedata <= sample_data;
                wr_ptr        <= wr_ptr + 1'b1;
                if (wr_ptr == '1) wrapped <= 1'b1;
                case (state_q)
                    ST_PRETRIG: pre_cnt <= pre_cnt + 1'b1;
                    ST_ARMED:   if (trigger) trig_addr <= wr_ptr;
                    ST_POST:    post_rem <= post_rem - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign ram_chipselect = write_q;
    assign ram_write      = write_q;
    assign ram_clken      = 1'b1;
    assign busy           = active;
    assign done           = (state_q == ST_DONE);

    generate
        if (DATA_W == DBG_DATA_W) begin : g_be_pkg
            assign ram_byteenable = DBG_BE_ALL;
        end else begin : g_be_gen
            assign ram_byteenable = {(DATA_W/8){1'b1}};
        end
    endgenerate

endmodule

// File: tb/tb_curr_ctrl_debug_capture.sv
// Directed self-checking bench for curr_ctrl_debug_capture (default build, no decimation).
module tb_curr_ctrl_debug_capture;

    logic        clk = 1'b0;
    logic        reset, arm, abort;
    logic [8:0]  post_len;
    logic        sample_valid;
    logic [31:0] sample_data;
    logic        trigger;
    logic [8:0]  ram_address;
    logic        ram_chipselect, ram_write;
    logic [31:0] ram_writedata;
    logic [3:0]  ram_byteenable;
    logic        ram_clken, busy, done, wrapped;
    logic [8:0]  trig_addr;

    int tests = 0;
    int fails = 0;

    logic [8:0]  wa[$];
    logic [31:0] wd[$];

    curr_ctrl_debug_capture dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .post_len(post_len),
        .sample_valid(sample_valid), .sample_data(sample_data), .trigger(trigger),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable), .ram_clken(ram_clken),
        .busy(busy), .done(done), .trig_addr(trig_addr), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_write === 1'b1) begin
            wa.push_back(ram_address);
            wd.push_back(ram_writedata);
        end
    end

    task automatic step(input logic v, input logic [31:0] d, input logic t);
        sample_valid = v;
        sample_data  = d;
        trigger      = t;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        trigger      = 1'b0;
    endtask

    task automatic pulse_arm(input logic [8:0] pl);
        arm      = 1'b1;
        post_len = pl;
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(1'b1, 32'hFFFF_FFFF, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        tests++; if (ram_write !== 1'b0 || ram_chipselect !== 1'b0) begin fails++; $display("FAIL reset_write: got we=%b cs=%b want 0 0", ram_write, ram_chipselect); end
        tests++; if (busy !== 1'b0 || done !== 1'b0 || wrapped !== 1'b0) begin fails++; $display("FAIL reset_flags: got busy=%b done=%b wrapped=%b want 0 0 0", busy, done, wrapped); end
        tests++; if (trig_addr !== 9'd0 || ram_address !== 9'd0 || ram_writedata !== 32'd0) begin fails++; $display("FAIL reset_regs: got trig=%0d addr=%0d data=%h want 0 0 0", trig_addr, ram_address, ram_writedata); end
        tests++; if (ram_byteenable !== 4'hF || ram_clken !== 1'b1) begin fails++; $display("FAIL reset_ties: got be=%h clken=%b want f 1", ram_byteenable, ram_clken); end
        reset = 1'b0;
        step(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_pretrig_fill;
        int bad = 0;
        pulse_arm(9'd20);
        wa.delete(); wd.delete();
        for (int i = 0; i < 64; i++) step(1'b1, 32'(i), (i == 10));
        step(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < wa.size(); i++) if (wa[i] !== 9'(i) || wd[i] !== 32'(i)) bad++;
        tests++; if (wa.size() != 64 || bad != 0) begin fails++; $display("FAIL pretrig_writes: got count=%0d bad=%0d want 64 0", wa.size(), bad); end
        tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL pretrig_flags: got busy=%b done=%b want 1 0", busy, done); end
        tests++; if (trig_addr !== 9'd0) begin fails++; $display("FAIL pretrig_trig_ignored: got trig_addr=%0d want 0", trig_addr); end
    endtask

    task automatic test_trigger_post;
        int bad = 0;
        wa.delete(); wd.delete();
        for (int i = 64; i <= 100; i++) step(1'b1, 32'(i), (i == 80));
        tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL post_done: got done=%b busy=%b want 1 0", done, busy); end
        tests++; if (trig_addr !== 9'd80) begin fails++; $display("FAIL post_trig_addr: got %0d want 80", trig_addr); end
        for (int i = 101; i <= 110; i++) step(1'b1, 32'(i), 1'b1);
        for (int i = 0; i < wa.size(); i++) if (wa[i] !== 9'(64 + i) || wd[i] !== 32'(64 + i)) bad++;
        tests++; if (wa.size() != 37 || bad != 0) begin fails++; $display("FAIL post_writes: got count=%0d bad=%0d want 37 0", wa.size(), bad); end
        tests++; if (wa.size() > 0 && wa[wa.size()-1] !== 9'd100) begin fails++; $display("FAIL post_last_addr: got %0d want 100", wa[wa.size()-1]); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL post_done_hold: got %b want 1", done); end
    endtask

    task automatic test_wrap;
        pulse_arm(9'd0);
        tests++; if (done !== 1'b0 || busy !== 1'b1 || trig_addr !== 9'd80) begin fails++; $display("FAIL rearm_state: got done=%b busy=%b trig=%0d want 0 1 80", done, busy, trig_addr); end
        wa.delete(); wd.delete();
        for (int i = 0; i <= 600; i++) begin
            step(1'b1, 32'(i), (i == 5) || (i == 600));
            if (i == 510) begin
                tests++; if (wrapped !== 1'b0) begin fails++; $display("FAIL wrap_early: got wrapped=%b want 0", wrapped); end
            end
            if (i == 511) begin
                tests++; if (wrapped !== 1'b1) begin fails++; $display("FAIL wrap_set: got wrapped=%b want 1", wrapped); end
            end
        end
        tests++; if (done !== 1'b1 || trig_addr !== 9'd88 || wrapped !== 1'b1) begin fails++; $display("FAIL wrap_done: got done=%b trig=%0d wrapped=%b want 1 88 1", done, trig_addr, wrapped); end
        step(1'b0, 32'h0, 1'b0);
        tests++;
        if (wa.size() != 601) begin
            fails++; $display("FAIL wrap_count: got %0d want 601", wa.size());
        end else if (wa[511] !== 9'd511 || wa[512] !== 9'd0 || wd[512] !== 32'd512 || wa[600] !== 9'd88 || wd[600] !== 32'd600) begin
            fails++; $display("FAIL wrap_addrs: got a511=%0d a512=%0d d512=%0d a600=%0d d600=%0d want 511 0 512 88 600", wa[511], wa[512], wd[512], wa[600], wd[600]);
        end
    endtask

    task automatic test_abort;
        int n;
        int bad = 0;
        pulse_arm(9'd10);
        tests++; if (wrapped !== 1'b0 || trig_addr !== 9'd88 || busy !== 1'b1) begin fails++; $display("FAIL abort_arm: got wrapped=%b trig=%0d busy=%b want 0 88 1", wrapped, trig_addr, busy); end
        wa.delete(); wd.delete();
        for (int i = 0; i <= 69; i++) begin
            arm = (i == 66);
            step(1'b1, 32'(i), (i == 64));
            arm = 1'b0;
        end
        tests++; if (busy !== 1'b1 || trig_addr !== 9'd64) begin fails++; $display("FAIL abort_post_state: got busy=%b trig=%0d want 1 64", busy, trig_addr); end
        n = wa.size();
        abort = 1'b1;
        step(1'b1, 32'hDEAD, 1'b0);
        abort = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 32'hBEEF, 1'b0);
        tests++; if (wa.size() - n != 1) begin fails++; $display("FAIL abort_extra_writes: got %0d want 1", wa.size() - n); end
        for (int i = 0; i < wa.size(); i++) if (wa[i] !== 9'(i) || wd[i] !== 32'(i)) bad++;
        tests++; if (wa.size() != 70 || bad != 0) begin fails++; $display("FAIL abort_sequence: got count=%0d bad=%0d want 70 0", wa.size(), bad); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_idle: got busy=%b done=%b want 0 0", busy, done); end
        pulse_arm(9'd20);
        wa.delete(); wd.delete();
        step(1'b1, 32'h1234, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        tests++; if (wa.size() != 1 || wa[0] !== 9'd0 || wd[0] !== 32'h1234) begin fails++; $display("FAIL abort_restart: got count=%0d want 1 write at addr 0 data 1234", wa.size()); end
    endtask

    task automatic test_arm_abort_same;
        abort = 1'b1;
        step(1'b0, 32'h0, 1'b0);
        wa.delete(); wd.delete();
        arm = 1'b1;
        step(1'b1, 32'h55, 1'b0);
        arm = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 32'(i), 1'b1);
        tests++; if (busy !== 1'b0 || done !== 1'b0 || wa.size() != 0) begin fails++; $display("FAIL arm_abort_same: got busy=%b done=%b writes=%0d want 0 0 0", busy, done, wa.size()); end
    endtask

    task automatic test_reset_mid;
        pulse_arm(9'd5);
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i), 1'b0);
        tests++; if (ram_write !== 1'b1) begin fails++; $display("FAIL reset_mid_pre: got we=%b want 1", ram_write); end
        reset = 1'b1;
        step(1'b1, 32'h77, 1'b0);
        tests++; if (ram_write !== 1'b0 || ram_chipselect !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_mid: got we=%b cs=%b busy=%b want 0 0 0", ram_write, ram_chipselect, busy); end
        reset = 1'b0;
        step(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; abort = 1'b0; post_len = '0;
        sample_valid = 1'b0; sample_data = '0; trigger = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_pretrig_fill();
        test_trigger_post();
        test_wrap();
        test_abort();
        test_arm_abort_same();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
